// File: rtl/grid_renderer.sv
// Grid overlay renderer: divides the active area into GRID_COLS x GRID_ROWS
// cells, asks an external cell memory for each cell's status and paints the
// pixel with grid lines, a blinking cursor, a hover tint or the status colour.
// Pipeline: inputs are sampled at edge 0; cell_x/cell_y are registered at
// that edge and the memory answers on cell_status during the following
// cycle; color_out is registered at edge 1, i.e. two cycles after the pixel
// was presented. Cell indices come from raster-following sub-pixel counters,
// so pixels are expected in raster order starting at x == 0 on every line.
module grid_renderer #(
  parameter int CELL_W       = 64,
  parameter int CELL_H       = 48,
  parameter int GRID_COLS    = 10,
  parameter int GRID_ROWS    = 10,
  parameter int LINE_T       = 2,
  parameter int CURSOR_R     = 5,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        enable,
  input  logic [9:0]  current_row,
  input  logic [9:0]  current_line,
  input  logic [9:0]  mouse_pos_x,
  input  logic [9:0]  mouse_pos_y,
  input  logic [1:0]  mode,
  output logic [3:0]  cell_x,
  output logic [3:0]  cell_y,
  input  logic [3:0]  cell_status,
  output logic [11:0] color_out
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [9:0]  SUB_X_MAX = 10'(CELL_W - 1);
  localparam logic [9:0]  SUB_Y_MAX = 10'(CELL_H - 1);
  localparam logic [3:0]  COL_MAX   = 4'(GRID_COLS - 1);
  localparam logic [3:0]  ROW_MAX   = 4'(GRID_ROWS - 1);
  // Sub-pixel window just below a cell boundary that still belongs to the line
  localparam logic [9:0]  LINE_LO_X = 10'(CELL_W - LINE_T + 1);
  localparam logic [9:0]  LINE_LO_Y = 10'(CELL_H - LINE_T + 1);
  localparam logic [9:0]  LINE_HI   = 10'(LINE_T);
  localparam logic [10:0] GRID_W    = 11'(GRID_COLS * CELL_W);
  localparam logic [10:0] GRID_H    = 11'(GRID_ROWS * CELL_H);
  localparam logic [10:0] CELL_W11  = 11'(CELL_W);
  localparam logic [10:0] CELL_H11  = 11'(CELL_H);
  localparam logic signed [10:0] CUR_POS = 11'(CURSOR_R);
  localparam logic signed [10:0] CUR_NEG = -CUR_POS;
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_CURSOR = 12'hF00;
  localparam logic [11:0] RGB_LINE   = 12'hF0F;
  localparam logic [11:0] RGB_HOVER  = 12'h08F;

  // Raster position state (describes the most recent enabled pixel)
  logic [9:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  logic [3:0] col_q, col_d, row_q, row_d;
  logic [9:0] sub_x_cur, sub_y_cur;
  logic [3:0] col_cur, row_cur;

  // Blink state
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          frame_start;

  // Stage-1 registers: cell address plus side information aligned with cell_status
  logic [3:0] cell_x_q, cell_x_d, cell_y_q, cell_y_d;
  logic       en_q, outside_q, cursor_q, line_q, hover_q, blink_en_q, hover_en_q;
  logic       outside_d, cursor_d, line_d, hover_d;

  // Stage-2 register
  logic [11:0] color_q, color_d, status_rgb;

  // Classification temporaries
  logic [9:0]         x0, y0;
  logic signed [10:0] dx, dy;
  logic               line_x, line_y, mouse_col, mouse_row;

  // Position of the current pixel derived from the previous one
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    sub_x_cur = sub_x_q;
    col_cur   = col_q;
    sub_y_cur = sub_y_q;
    row_cur   = row_q;
    if (current_row == 10'd0) begin
      sub_x_cur = 10'd0;
      col_cur   = 4'd0;
      if (current_line == 10'd0) begin
        sub_y_cur = 10'd0;
        row_cur   = 4'd0;
      end else if (sub_y_q == SUB_Y_MAX) begin
        sub_y_cur = 10'd0;
        if (row_q != ROW_MAX) row_cur = row_q + 4'd1;
      end else begin
        sub_y_cur = sub_y_q + 10'd1;
      end
    end else if (sub_x_q == SUB_X_MAX) begin
      sub_x_cur = 10'd0;
      if (col_q != COL_MAX) col_cur = col_q + 4'd1;
    end else begin
      sub_x_cur = sub_x_q + 10'd1;
    end

    sub_x_d  = enable ? sub_x_cur : sub_x_q;
    col_d    = enable ? col_cur   : col_q;
    sub_y_d  = enable ? sub_y_cur : sub_y_q;
    row_d    = enable ? row_cur   : row_q;
    cell_x_d = enable ? col_cur   : cell_x_q;
    cell_y_d = enable ? row_cur   : cell_y_q;
  end

  // Frame counting for the cursor blink
  always_comb begin
    frame_start   = enable && (current_row == 10'd0) && (current_line == 10'd0);
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (frame_cnt_q == FRAME_MAX) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  // Per-pixel classification: outside, grid line, cursor box, mouse cell
  always_comb begin
    outside_d = ({1'b0, current_row} >= GRID_W) || ({1'b0, current_line} >= GRID_H);

    // Lower half of a line sits at the end of cell k-1, upper half at the start of cell k
    line_x = ((col_cur != COL_MAX) && (sub_x_cur >= LINE_LO_X)) ||
             ((col_cur != 4'd0)    && (sub_x_cur <= LINE_HI));
    line_y = ((row_cur != ROW_MAX) && (sub_y_cur >= LINE_LO_Y)) ||
             ((row_cur != 4'd0)    && (sub_y_cur <= LINE_HI));
    line_d = line_x || line_y;

    // Widening to 11 bits keeps the distance exact near both ends of the range
    dx = $signed({1'b0, current_row})  - $signed({1'b0, mouse_pos_x});
    dy = $signed({1'b0, current_line}) - $signed({1'b0, mouse_pos_y});
    cursor_d = (dx >= CUR_NEG) && (dx <= CUR_POS) && (dy >= CUR_NEG) && (dy <= CUR_POS);

    // Mouse shares the cell if it falls inside this cell's span; the last
    // column/row extends to infinity to match the clamped index
    x0 = current_row  - sub_x_cur;
    y0 = current_line - sub_y_cur;
    mouse_col = (mouse_pos_x >= x0) &&
                ((col_cur == COL_MAX) || ({1'b0, mouse_pos_x} < ({1'b0, x0} + CELL_W11)));
    mouse_row = (mouse_pos_y >= y0) &&
                ((row_cur == ROW_MAX) || ({1'b0, mouse_pos_y} < ({1'b0, y0} + CELL_H11)));
    hover_d = mouse_col && mouse_row;
  end

  // Final colour selection in priority order, using the memory reply
  always_comb begin
    case (cell_status)
      4'd1:    status_rgb = 12'h555;
      4'd2:    status_rgb = 12'hE88;
      4'd3:    status_rgb = 12'hF00;
      4'd4:    status_rgb = 12'hF06;
      default: status_rgb = 12'h2B0;
    endcase

    if (!en_q || outside_q) begin
      color_d = RGB_BLACK;
    end else if (cursor_q && (!blink_en_q || !blink_phase_q)) begin
      color_d = RGB_CURSOR;
    end else if (line_q) begin
      color_d = RGB_LINE;
    end else if (hover_en_q && hover_q && (cell_status == 4'd0)) begin
      color_d = RGB_HOVER;
    end else begin
      color_d = status_rgb;
    end
  end

  // All state with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sub_x_q       <= '0;
      sub_y_q       <= '0;
      col_q         <= '0;
      row_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      cell_x_q      <= '0;
      cell_y_q      <= '0;
      en_q          <= 1'b0;
      outside_q     <= 1'b0;
      cursor_q      <= 1'b0;
      line_q        <= 1'b0;
      hover_q       <= 1'b0;
      blink_en_q    <= 1'b0;
      hover_en_q    <= 1'b0;
      color_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      sub_x_q       <= sub_x_d;
      sub_y_q       <= sub_y_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      cell_x_q      <= cell_x_d;
      cell_y_q      <= cell_y_d;
      en_q          <= enable;
      outside_q     <= outside_d;
      cursor_q      <= cursor_d;
      line_q        <= line_d;
      hover_q       <= hover_d;
      blink_en_q    <= mode[0];
      hover_en_q    <= mode[1];
      color_q       <= color_d;
    end
  end

  assign cell_x    = cell_x_q;
  assign cell_y    = cell_y_q;
  assign color_out = color_q;

endmodule

// File: tb/tb_grid_renderer.sv
// Testbench for grid_renderer: raster stimulus with random gaps, a cell
// memory answering combinationally from cell_x/cell_y, and a scoreboard fed
// by a reference model that works from pixel coordinates directly.
module tb_grid_renderer;

  localparam int CELL_W       = 64;
  localparam int CELL_H       = 48;
  localparam int GRID_COLS    = 10;
  localparam int GRID_ROWS    = 10;
  localparam int LINE_T       = 2;
  localparam int CURSOR_R     = 5;
  localparam int BLINK_FRAMES = 30;

  logic        clk_in = 1'b0;
  logic        reset_in, enable;
  logic [9:0]  current_row, current_line, mouse_pos_x, mouse_pos_y;
  logic [1:0]  mode;
  logic [3:0]  cell_x, cell_y, cell_status;
  logic [11:0] color_out;

  logic [3:0] mem [16][16];

  grid_renderer #(
    .CELL_W(CELL_W), .CELL_H(CELL_H), .GRID_COLS(GRID_COLS), .GRID_ROWS(GRID_ROWS),
    .LINE_T(LINE_T), .CURSOR_R(CURSOR_R), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .enable(enable),
    .current_row(current_row), .current_line(current_line),
    .mouse_pos_x(mouse_pos_x), .mouse_pos_y(mouse_pos_y), .mode(mode),
    .cell_x(cell_x), .cell_y(cell_y), .cell_status(cell_status), .color_out(color_out)
  );

  // Cell memory: replies for the address currently presented
  assign cell_status = mem[cell_y][cell_x];

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  typedef struct { int due; logic [11:0] exp; int x; int y; } color_item_t;
  typedef struct { int due; logic [3:0] ex_cx; logic [3:0] ex_cy; int x; int y; } cell_item_t;
  color_item_t color_sb[$];
  cell_item_t  cell_sb[$];

  task automatic check(input string name, input int x, input int y,
                       input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s pixel(%0d,%0d): got %h expected %h", name, x, y, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [11:0] status_color(input logic [3:0] s);
    case (s)
      4'd1:    return 12'h555;
      4'd2:    return 12'hE88;
      4'd3:    return 12'hF00;
      4'd4:    return 12'hF06;
      default: return 12'h2B0;
    endcase
  endfunction

  function automatic bit on_line(input int p, input int pitch, input int n);
    for (int k = 1; k < n; k++)
      if (p > k * pitch - LINE_T && p <= k * pitch + LINE_T) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [11:0] model_color(input bit en, input int x, input int y);
    int mx = int'(mouse_pos_x);
    int my = int'(mouse_pos_y);
    int col = min_i(x / CELL_W, GRID_COLS - 1);
    int row = min_i(y / CELL_H, GRID_ROWS - 1);
    bit cur, vis;
    logic [3:0] st;
    if (!en) return 12'h000;
    if (x >= GRID_COLS * CELL_W || y >= GRID_ROWS * CELL_H) return 12'h000;
    cur = (x - mx <= CURSOR_R) && (mx - x <= CURSOR_R) &&
          (y - my <= CURSOR_R) && (my - y <= CURSOR_R);
    vis = !mode[0] || ((n_frames / BLINK_FRAMES) % 2 == 0);
    if (cur && vis) return 12'hF00;
    if (on_line(x, CELL_W, GRID_COLS) || on_line(y, CELL_H, GRID_ROWS)) return 12'hF0F;
    st = mem[row][col];
    if (mode[1] && st == 4'd0 && col == min_i(mx / CELL_W, GRID_COLS - 1) &&
        row == min_i(my / CELL_H, GRID_ROWS - 1)) return 12'h08F;
    return status_color(st);
  endfunction

  // ---------------- monitor ----------------
  color_item_t mon_c;
  cell_item_t  mon_e;
  always @(negedge clk_in) begin
    while (cell_sb.size() > 0 && cell_sb[0].due <= cyc) begin
      mon_e = cell_sb.pop_front();
      check("cell_x", mon_e.x, mon_e.y, {8'h00, cell_x}, {8'h00, mon_e.ex_cx});
      check("cell_y", mon_e.x, mon_e.y, {8'h00, cell_y}, {8'h00, mon_e.ex_cy});
    end
    while (color_sb.size() > 0 && color_sb[0].due <= cyc) begin
      mon_c = color_sb.pop_front();
      check("color", mon_c.x, mon_c.y, color_out, mon_c.exp);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit en, input int x, input int y);
    color_item_t c;
    cell_item_t  e;
    @(negedge clk_in);
    enable       = en;
    current_row  = 10'(x);
    current_line = 10'(y);
    if (en && x == 0 && y == 0) n_frames++;
    c.due = cyc + 2; c.exp = model_color(en, x, y); c.x = x; c.y = y;
    color_sb.push_back(c);
    if (en) begin
      e.due = cyc + 1; e.x = x; e.y = y;
      e.ex_cx = 4'(min_i(x / CELL_W, GRID_COLS - 1));
      e.ex_cy = 4'(min_i(y / CELL_H, GRID_ROWS - 1));
      cell_sb.push_back(e);
    end
  endtask

  task automatic scan_line(input int y, input int x_last);
    for (int x = 0; x <= x_last; x++) begin
      if ($urandom_range(0, 15) == 0)
        drive(1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      drive(1'b1, x, y);
    end
  endtask

  task automatic frame(input int y_last, input int y_lo, input int x_last);
    for (int y = 0; y <= y_last; y++) scan_line(y, (y >= y_lo) ? x_last : 0);
  endtask

  task automatic drain();
    drive(1'b0, 0, 0);
    drive(1'b0, 0, 0);
    for (int i = 0; i < 8 && (color_sb.size() > 0 || cell_sb.size() > 0); i++)
      @(negedge clk_in);
    if (color_sb.size() > 0 || cell_sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d results still pending, required 0", color_sb.size() + cell_sb.size());
      color_sb.delete();
      cell_sb.delete();
    end
  endtask

  // Reset pulse in the middle of whatever is in flight
  task automatic do_reset();
    @(negedge clk_in);
    color_sb.delete();
    cell_sb.delete();
    reset_in     = 1'b1;
    enable       = 1'b1;
    current_row  = 10'(200);
    current_line = 10'(77);
    @(negedge clk_in);
    check("reset_color", 200, 77, color_out, 12'h000);
    check("reset_cell_x", 200, 77, {8'h00, cell_x}, 12'h000);
    check("reset_cell_y", 200, 77, {8'h00, cell_y}, 12'h000);
    reset_in = 1'b0;
    enable   = 1'b0;
    n_frames = 0;
    repeat (3) drive(1'b0, 0, 0);
  endtask

  task automatic randomize_mem(input int max_status);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mem[r][c] = 4'($urandom_range(0, max_status));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in     = 1'b1;
    enable       = 1'b0;
    current_row  = '0;
    current_line = '0;
    mode         = 2'b00;
    mouse_pos_x  = 10'd1000;
    mouse_pos_y  = 10'd1000;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mem[r][c] = 4'd0;
    repeat (2) @(negedge clk_in);
    check("init_color", 0, 0, color_out, 12'h000);
    check("init_cell_x", 0, 0, {8'h00, cell_x}, 12'h000);
    check("init_cell_y", 0, 0, {8'h00, cell_y}, 12'h000);
    reset_in = 1'b0;

    // First line, all status 0: boundary at x=64, line pixels 63..66
    scan_line(0, 127);
    drain();

    // Cursor box around (100,100) with random statuses, then mid-frame reset
    randomize_mem(7);
    mouse_pos_x = 10'd100;
    mouse_pos_y = 10'd100;
    frame(110, 90, 110);
    do_reset();

    // Cursor near the origin, then a full-width line past the grid edge
    mouse_pos_x = 10'd2;
    mouse_pos_y = 10'd2;
    scan_line(0, 10);
    mouse_pos_x = 10'd0;
    mouse_pos_y = 10'd0;
    scan_line(0, 1023);
    do_reset();

    // Blink: hidden after 30 frame starts, visible again after 60
    mode        = 2'b01;
    mouse_pos_x = 10'd20;
    mouse_pos_y = 10'd20;
    for (int f = 0; f < 61; f++) frame(22, 18, 25);
    drain();

    // Hover tint on cell (2,3), status 0 then status 1
    mode        = 2'b10;
    mouse_pos_x = 10'd150;
    mouse_pos_y = 10'd160;
    mem[3][2]   = 4'd0;
    frame(195, 140, 195);
    drain();
    mem[3][2] = 4'd1;
    frame(195, 140, 195);
    drain();

    // Random full-height frames with random mode, mouse and statuses
    for (int i = 0; i < 3; i++) begin
      randomize_mem(6);
      mode        = 2'($urandom_range(0, 3));
      mouse_pos_x = 10'($urandom_range(0, 1023));
      mouse_pos_y = 10'($urandom_range(0, 1023));
      for (int y = 0; y < GRID_ROWS * CELL_H; y++)
        scan_line(y, ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 700)) : 0);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
